// File: rtl/snitch_tcdm_bank_pkg.sv
// Shared types for the TCDM bank responder: AMO opcodes, FSM states
// and response mux selects.
package snitch_tcdm_bank_pkg;

  localparam int unsigned AmoWidth = 32;

  typedef enum logic [3:0] {
    AmoNone = 4'd0,
    AmoSwap = 4'd1,
    AmoAdd  = 4'd2,
    AmoAnd  = 4'd3,
    AmoOr   = 4'd4,
    AmoXor  = 4'd5,
    AmoMax  = 4'd6,
    AmoMaxu = 4'd7,
    AmoMin  = 4'd8,
    AmoMinu = 4'd9,
    AmoLr   = 4'd10,
    AmoSc   = 4'd11
  } amo_op_e;

  typedef enum logic {
    IDLE,
    AMO_WB
  } state_e;

  typedef enum logic [1:0] {
    RespZero,
    RespSram,
    RespSc
  } resp_sel_e;

  function automatic logic is_rmw(logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd9);
  endfunction

endpackage

// File: rtl/snitch_tcdm_amo_alu.sv
// Combinational 32-bit RISC-V AMO arithmetic: result = op(old, operand).
module snitch_tcdm_amo_alu
  import snitch_tcdm_bank_pkg::*;
(
  input  amo_op_e             op,
  input  logic [AmoWidth-1:0] old,
  input  logic [AmoWidth-1:0] operand,
  output logic [AmoWidth-1:0] result
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(old) < $signed(operand);
  assign lt_u = old < operand;

  always_comb begin
    result = old;
    unique case (op)
      AmoSwap: result = operand;
      AmoAdd:  result = old + operand;
      AmoAnd:  result = old & operand;
      AmoOr:   result = old | operand;
      AmoXor:  result = old ^ operand;
      AmoMax:  result = lt_s ? operand : old;
      AmoMaxu: result = lt_u ? operand : old;
      AmoMin:  result = lt_s ? old : operand;
      AmoMinu: result = lt_u ? old : operand;
      default: result = old;
    endcase
  end

endmodule

// File: rtl/snitch_tcdm_bank_responder.sv
// TCDM bank endpoint: SRAM driver with 1-cycle responses and local AMOs.
// Optional LR/SC reservation enabled by SNITCH_TCDM_BANK_LRSC_EN.
module snitch_tcdm_bank_responder
  import snitch_tcdm_bank_pkg::*;
#(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned UserWidth = 8,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_q_valid_i,
  output logic                 mem_q_ready_o,
  input  logic [AddrWidth-1:0] mem_q_addr_i,
  input  logic                 mem_q_write_i,
  input  logic [3:0]           mem_q_amo_i,
  input  logic [DataWidth-1:0] mem_q_data_i,
  input  logic [StrbWidth-1:0] mem_q_strb_i,
  input  logic [UserWidth-1:0] mem_q_user_i,
  output logic [DataWidth-1:0] mem_p_data_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [StrbWidth-1:0] sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  state_e                 state;
  resp_sel_e              sel_q;
  amo_op_e                op, op_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [AmoWidth-1:0]    operand_q;
  logic [AmoWidth-1:0]    lane_in, old_lane, result;
  logic [DataWidth-1:0]   wdata_amo;
  logic [StrbWidth-1:0]   be_amo;
  logic accept, rmw, lr, sc, sc_fail, sc_flag_q;

  assign op = amo_op_e'(mem_q_amo_i);
  assign rmw = is_rmw(mem_q_amo_i);
  assign lr = mem_q_amo_i == AmoLr;
  assign sc = mem_q_amo_i == AmoSc;
  assign mem_q_ready_o = (state == IDLE) && !rst_i;
  assign accept = mem_q_valid_i && mem_q_ready_o;

  if (DataWidth == 64) begin : g_w64
    logic hi, hi_q;
    assign hi = |mem_q_strb_i[7:4];
    always_ff @(posedge clk_i) begin
      if (accept && rmw) hi_q <= hi;
    end
    assign lane_in = hi ? mem_q_data_i[63:32] : mem_q_data_i[31:0];
    assign old_lane = hi_q ? sram_rdata_i[63:32] : sram_rdata_i[31:0];
    assign wdata_amo = {result, result};
    assign be_amo = hi_q ? 8'hF0 : 8'h0F;
  end else begin : g_w32
    assign lane_in = mem_q_data_i;
    assign old_lane = sram_rdata_i;
    assign wdata_amo = result;
    assign be_amo = '1;
  end

  snitch_tcdm_amo_alu i_alu (
    .op      (op_q),
    .old     (old_lane),
    .operand (operand_q),
    .result  (result)
  );

`ifdef SNITCH_TCDM_BANK_LRSC_EN
  logic                 resv_valid;
  logic [AddrWidth-1:0] resv_addr;
  logic [UserWidth-1:0] resv_user;
  logic                 hit;

  assign hit = resv_valid && (resv_addr == mem_q_addr_i);
  assign sc_fail = !(hit && (resv_user == mem_q_user_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resv_valid <= 1'b0;
    end else if (accept) begin
      if (lr) begin
        resv_valid <= 1'b1;
        resv_addr  <= mem_q_addr_i;
        resv_user  <= mem_q_user_i;
      end else if (sc) begin
        resv_valid <= 1'b0;
      end else if (hit && (rmw || mem_q_write_i)) begin
        resv_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_user;
  assign unused_user = ^mem_q_user_i;
  assign sc_fail = 1'b0;
`endif

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = mem_q_addr_i;
    sram_wdata_o = mem_q_data_i;
    sram_be_o    = '0;
    if (rst_i) begin
      sram_req_o = 1'b0;
    end else if (state == AMO_WB) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = addr_q;
      sram_wdata_o = wdata_amo;
      sram_be_o    = be_amo;
    end else if (mem_q_valid_i) begin
      sram_be_o = mem_q_strb_i;
      unique case (1'b1)
        rmw, lr: sram_req_o = 1'b1;
        sc: begin
          sram_req_o = !sc_fail;
          sram_we_o  = !sc_fail;
        end
        default: begin
          sram_req_o = 1'b1;
          sram_we_o  = mem_q_write_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sel_q     <= RespZero;
      sc_flag_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sel_q     <= sc ? RespSc : RespSram;
            sc_flag_q <= sc_fail;
            if (rmw) begin
              state     <= AMO_WB;
              addr_q    <= mem_q_addr_i;
              operand_q <= lane_in;
              op_q      <= op;
            end
          end
        end
        AMO_WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_p_data_o = '0;
    unique case (sel_q)
      RespSram: mem_p_data_o = sram_rdata_i;
      RespSc:   mem_p_data_o = DataWidth'(sc_flag_q);
      default:  mem_p_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_snitch_tcdm_bank_responder.sv
// Scoreboard bench for snitch_tcdm_bank_responder with a behavioural SRAM.
module tb_snitch_tcdm_bank_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_valid = 1'b0;
  logic        q_ready;
  logic [9:0]  q_addr = '0;
  logic        q_write = 1'b0;
  logic [3:0]  q_amo = '0;
  logic [31:0] q_data = '0;
  logic [3:0]  q_strb = 4'hF;
  logic [7:0]  q_user = '0;
  logic [31:0] p_data;
  logic        sram_req, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata = '0;

  logic [31:0] mem [1024];
  logic [32:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  snitch_tcdm_bank_responder dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_q_valid_i (q_valid),
    .mem_q_ready_o (q_ready),
    .mem_q_addr_i  (q_addr),
    .mem_q_write_i (q_write),
    .mem_q_amo_i   (q_amo),
    .mem_q_data_i  (q_data),
    .mem_q_strb_i  (q_strb),
    .mem_q_user_i  (q_user),
    .mem_p_data_o  (p_data),
    .sram_req_o    (sram_req),
    .sram_we_o     (sram_we),
    .sram_addr_o   (sram_addr),
    .sram_wdata_o  (sram_wdata),
    .sram_be_o     (sram_be),
    .sram_rdata_i  (sram_rdata)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      sram_rdata <= mem[sram_addr];
    end
  end

  // Monitor: a handshake seen at one negedge owes a response at the next.
  initial begin
    logic pend;
    logic [32:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected got=%h", p_data);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) begin
            checks++;
            if (p_data !== e[31:0]) begin
              errors++;
              $display("FAIL resp got=%h exp=%h", p_data, e[31:0]);
            end
          end
        end
      end
      pend = q_valid && q_ready;
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance, valid low.
  task automatic issue(input logic w, input logic [3:0] op,
                       input logic [9:0] a, input logic [31:0] d,
                       input logic [7:0] u, input logic care,
                       input logic [31:0] exp, output int cyc);
    bit done;
    done = 0;
    cyc = -1;
    q_valid = 1'b1;
    q_write = w;
    q_amo = op;
    q_addr = a;
    q_data = d;
    q_user = u;
    q_strb = 4'hF;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (q_ready) begin
        exp_q.push_back({care, exp});
        cyc = cycle;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    q_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0d addr=%0d", op, a);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    int c;
    issue(1'b1, 4'd0, a, d, 8'd0, 1'b0, 32'h0, c);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp);
    int c;
    issue(1'b0, 4'd0, a, 32'h0, 8'd0, 1'b1, exp, c);
  endtask

  task automatic amo(input logic [3:0] op, input logic [9:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    int c;
    issue(1'b0, op, a, d, 8'd0, 1'b1, exp, c);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, c2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(q_ready), 32'h0);
    chk("rst_req", 32'(sram_req), 32'h0);
    chk("rst_we", 32'(sram_we), 32'h0);
    chk("rst_be", 32'(sram_be), 32'h0);
    chk("rst_pdata", p_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b1, 4'd0, 10'd5, 32'hDEADBEEF, 8'd0, 1'b0, 32'h0, c0);
    issue(1'b0, 4'd0, 10'd5, 32'h0, 8'd0, 1'b1, 32'hDEADBEEF, c1);
    chk("wr_rd_b2b", 32'(c1 - c0), 32'd1);

    wr(10'd3, 32'h7FFFFFFF);
    amo(4'd2, 10'd3, 32'h1, 32'h7FFFFFFF);
    @(negedge clk);
    chk("amo_wb_ready", 32'(q_ready), 32'h0);
    @(posedge clk);
    #1;
    rd(10'd3, 32'h80000000);

    wr(10'd4, 32'hFFFFFFFF);
    amo(4'd6, 10'd4, 32'h0, 32'hFFFFFFFF);
    rd(10'd4, 32'h0);
    wr(10'd4, 32'hFFFFFFFF);
    amo(4'd7, 10'd4, 32'h0, 32'hFFFFFFFF);
    rd(10'd4, 32'hFFFFFFFF);

    wr(10'd9, 32'h5);
    amo(4'd8, 10'd9, 32'hFFFFFFFE, 32'h5);
    rd(10'd9, 32'hFFFFFFFE);
    amo(4'd9, 10'd9, 32'h3, 32'hFFFFFFFE);
    rd(10'd9, 32'h3);
    amo(4'd5, 10'd9, 32'hF, 32'h3);
    amo(4'd1, 10'd9, 32'h55, 32'hC);
    amo(4'd4, 10'd9, 32'h0A, 32'h55);
    amo(4'd3, 10'd9, 32'hF0, 32'h5F);
    rd(10'd9, 32'h50);

    issue(1'b0, 4'd0, 10'd5, 32'h0, 8'd0, 1'b1, 32'hDEADBEEF, c0);
    issue(1'b0, 4'd3, 10'd7, 32'hFFFFFFFF, 8'd0, 1'b1, 32'h0, c1);
    issue(1'b0, 4'd0, 10'd5, 32'h0, 8'd0, 1'b1, 32'hDEADBEEF, c2);
    chk("stream_amo_gap", 32'(c1 - c0), 32'd1);
    chk("stream_after_amo", 32'(c2 - c0), 32'd3);

    issue(1'b1, 4'd12, 10'd10, 32'h00001234, 8'd0, 1'b0, 32'h0, c0);
    rd(10'd10, 32'h00001234);

`ifdef SNITCH_TCDM_BANK_LRSC_EN
    issue(1'b0, 4'd10, 10'd8, 32'h0, 8'd2, 1'b1, 32'h0, c0);
    issue(1'b1, 4'd11, 10'd8, 32'hAAAA5555, 8'd2, 1'b1, 32'h0, c0);
    rd(10'd8, 32'hAAAA5555);
    issue(1'b0, 4'd10, 10'd8, 32'h0, 8'd2, 1'b1, 32'hAAAA5555, c0);
    issue(1'b1, 4'd0, 10'd8, 32'h12345678, 8'd1, 1'b0, 32'h0, c0);
    issue(1'b1, 4'd11, 10'd8, 32'h0BADF00D, 8'd2, 1'b1, 32'h1, c0);
    rd(10'd8, 32'h12345678);
`else
    issue(1'b0, 4'd10, 10'd8, 32'h0, 8'd2, 1'b1, 32'h0, c0);
    issue(1'b1, 4'd11, 10'd8, 32'hAAAA5555, 8'd2, 1'b1, 32'h0, c0);
    rd(10'd8, 32'hAAAA5555);
`endif

    wr(10'd6, 32'h11111111);
    amo(4'd1, 10'd6, 32'h22222222, 32'h11111111);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(q_ready), 32'h0);
    chk("abort_req", 32'(sram_req), 32'h0);
    chk("abort_we", 32'(sram_we), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pdata", p_data, 32'h0);
    chk("post_rst_ready", 32'(q_ready), 32'h1);
    @(posedge clk);
    #1;
    rd(10'd6, 32'h11111111);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
